// File: rtl/serdes_rx_pkg.sv
// rtl/serdes_rx_pkg.sv - shared constants and types for the serdes receive path
package serdes_rx_pkg;

  // Width of one 8b10b code group
  localparam int SYMBOL_W = 10;

  // K28.5 comma in both running disparities, first-received bit in [9]
  localparam logic [SYMBOL_W-1:0] K28_5_RDN = 10'b0011111010;
  localparam logic [SYMBOL_W-1:0] K28_5_RDP = 10'b1100000101;

  // Width of the comma timeout symbol counter
  localparam int TO_CNT_W = 16;

  // Aligner lock state
  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } align_state_t;

  // Saturating increment for 8-bit event counters
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/comma_detector.sv
// rtl/comma_detector.sv - combinational K28.5 match against both disparities
module comma_detector
  import serdes_rx_pkg::*;
(
  input  logic [SYMBOL_W-1:0] sym,
  output logic                is_comma
);

  // Either disparity of K28.5 counts as a comma
  always_comb begin
    is_comma = (sym == K28_5_RDN) || (sym == K28_5_RDP);
  end

endmodule

// File: rtl/rx_comma_aligner.sv
// rtl/rx_comma_aligner.sv - slices equalized bits and aligns them to 8b10b symbols
module rx_comma_aligner
  import serdes_rx_pkg::*;
#(
  parameter real THRESHOLD      = 0.5,
  parameter int  MISALIGN_LIMIT = 3,
  parameter int  COMMA_TIMEOUT  = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  real                 data_in,
  output logic [SYMBOL_W-1:0] symbol_out,
  output logic                symbol_valid,
  output logic                aligned,
  output logic                comma_det,
  output logic [7:0]          realign_count
);

  localparam logic [3:0]          MIS_LIM = MISALIGN_LIMIT[3:0];
  localparam logic [TO_CNT_W-1:0] TO_LIM  = COMMA_TIMEOUT[TO_CNT_W-1:0];
  localparam logic                TO_EN   = (COMMA_TIMEOUT != 0);

  align_state_t        state, state_nxt;
  logic [SYMBOL_W-1:0] sr;
  logic [SYMBOL_W-1:0] sr_next;
  logic [3:0]          bit_cnt, bit_cnt_nxt;
  logic [3:0]          mis_cnt, mis_nxt;
  logic [TO_CNT_W-1:0] to_cnt, to_nxt;
  logic [3:0]          fill_cnt, fill_nxt;
  logic [SYMBOL_W-1:0] sym_nxt;
  logic                valid_nxt;
  logic                aligned_nxt;
  logic [7:0]          realign_nxt;

  logic                bit_in;
  logic                raw_comma;
  logic                primed;
  logic                comma_hit;
  logic                boundary;
  logic [3:0]          mis_inc;
  logic [TO_CNT_W-1:0] to_inc;

  // Hard slicer plus the shift-register look-ahead the comma match runs on
  always_comb begin
    bit_in  = (data_in >= THRESHOLD);
    sr_next = {sr[SYMBOL_W-2:0], bit_in};
  end

  comma_detector u_comma_detector (
    .sym      (sr_next),
    .is_comma (raw_comma)
  );

  // A match only counts once sr_next holds ten bits received since reset,
  // so the cleared shift register cannot supply the leading zeros of a comma
  always_comb begin
    primed    = (fill_cnt == 4'd9);
    fill_nxt  = primed ? fill_cnt : fill_cnt + 4'd1;
    comma_hit = raw_comma && primed;
    boundary  = (state == LOCKED) && (bit_cnt == 4'd9);
    mis_inc   = mis_cnt + 4'd1;
    to_inc    = to_cnt + 1'b1;
  end

  // Next-state and output decode for the HUNT/LOCKED supervisor
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
    mis_nxt     = mis_cnt;
    to_nxt      = to_cnt;
    sym_nxt     = symbol_out;
    valid_nxt   = 1'b0;
    realign_nxt = realign_count;

    case (state)
      HUNT: begin
        // Phase is meaningless until the first comma fixes it
        bit_cnt_nxt = 4'd0;
        if (comma_hit) begin
          state_nxt = LOCKED;
          sym_nxt   = sr_next;
          valid_nxt = 1'b1;
          mis_nxt   = 4'd0;
          to_nxt    = '0;
        end
      end

      LOCKED: begin
        if (boundary) begin
          sym_nxt   = sr_next;
          valid_nxt = 1'b1;
          if (comma_hit) begin
            // On-phase comma wins over any timeout progress
            mis_nxt = 4'd0;
            to_nxt  = '0;
          end else if (TO_EN && (to_inc == TO_LIM)) begin
            state_nxt = HUNT;
            mis_nxt   = 4'd0;
            to_nxt    = '0;
          end else begin
            to_nxt = to_inc;
          end
        end else if (comma_hit) begin
          if (mis_inc >= MIS_LIM) begin
            // Adopt the new phase now; the partial old-phase symbol is dropped
            bit_cnt_nxt = 4'd0;
            sym_nxt     = sr_next;
            valid_nxt   = 1'b1;
            mis_nxt     = 4'd0;
            to_nxt      = '0;
            realign_nxt = sat_inc8(realign_count);
          end else begin
            mis_nxt = mis_inc;
          end
        end
      end

      default: begin
        state_nxt = HUNT;
      end
    endcase

    aligned_nxt = (state_nxt == LOCKED);
  end

  // State, counters, shift register and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= HUNT;
      sr            <= '0;
      bit_cnt       <= 4'd0;
      mis_cnt       <= 4'd0;
      to_cnt        <= '0;
      fill_cnt      <= 4'd0;
      symbol_out    <= '0;
      symbol_valid  <= 1'b0;
      aligned       <= 1'b0;
      comma_det     <= 1'b0;
      realign_count <= 8'd0;
    end else begin
      state         <= state_nxt;
      sr            <= sr_next;
      bit_cnt       <= bit_cnt_nxt;
      mis_cnt       <= mis_nxt;
      to_cnt        <= to_nxt;
      fill_cnt      <= fill_nxt;
      symbol_out    <= sym_nxt;
      symbol_valid  <= valid_nxt;
      aligned       <= aligned_nxt;
      comma_det     <= comma_hit;
      realign_count <= realign_nxt;
    end
  end

endmodule

// File: doc/rx_comma_aligner.md
# rx_comma_aligner

Receive-side symbol aligner directly downstream of the RX equalizer. It slices the equalizer's real-valued 0/1 bit stream into 10-bit 8b10b code groups. It finds the symbol boundary by K28.5 comma detection and maintains lock with misalignment and timeout supervision. Its output feeds the 8b10b decoder.

## Interface
- `THRESHOLD`, 0.5, real slicing level: input `>= THRESHOLD` is a 1.
- `MISALIGN_LIMIT`, 3, consecutive off-phase commas that force a re-phase (1..15).
- `COMMA_TIMEOUT`, 256, symbols without any comma before lock is dropped; 0 disables.
- `clk`  in  1  bit clock, one bit per rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `data_in`  in  real  equalized bit, 0.0 or 1.0 nominal.
- `symbol_out`  out  10  aligned code group; `[9]` is the first-received bit ('a').
- `symbol_valid`  out  1  one-cycle strobe when `symbol_out` is updated.
- `aligned`  out  1  high in LOCKED state.
- `comma_det`  out  1  one-cycle pulse on any comma match, at any phase.
- `realign_count`  out  8  saturating count of re-phase events since reset.

## Operation
- **Shift register:** `sr_next = {sr[8:0], bit}`, where `bit = (data_in >= THRESHOLD)`. The comma match is combinational on `sr_next`.
- **Comma patterns:** `sr_next == 10'b0011111010` (RD-) or `10'b1100000101` (RD+). `comma_det` is the registered match.
- **Phase:** `bit_cnt` runs 0..9. A symbol boundary occurs on the edge where `bit_cnt == 9`.
- **HUNT** (reset state):
  - `symbol_valid` and `aligned` stay low.
  - On a comma: `bit_cnt <= 0`, `symbol_out <= sr_next`, `symbol_valid <= 1`, go to LOCKED.
- **LOCKED, at a boundary:**
  - `symbol_out <= sr_next`, `symbol_valid <= 1`, `bit_cnt <= 0`.
  - If the symbol is a comma: `mis_cnt <= 0` and `to_cnt <= 0`. Otherwise `to_cnt++`.
- **LOCKED, comma at a non-boundary:**
  - `mis_cnt++`.
  - When `mis_cnt` reaches `MISALIGN_LIMIT`, re-phase on this edge: `bit_cnt <= 0`, emit `sr_next` as a valid symbol, `mis_cnt <= 0`, `to_cnt <= 0`, `realign_count++` (saturates at 255).
  - The partial old-phase symbol is discarded. `aligned` stays high.
- **Timeout:** in LOCKED, when `to_cnt` reaches `COMMA_TIMEOUT` (nonzero), go to HUNT and clear `mis_cnt`/`to_cnt`. `aligned` drops on that edge.
- **Simultaneous events:** an on-phase comma clears `mis_cnt`, and this takes priority over the timeout increment. A re-phase and a boundary cannot coincide, because the re-phase condition requires a non-boundary position.
- **Reset values:**
  - `symbol_out = 0`, `symbol_valid = 0`, `aligned = 0`, `comma_det = 0`, `realign_count = 0`.
  - `sr = 0`, `bit_cnt = 0`, state HUNT.

## Timing
- All outputs are registered.
- The edge that samples the tenth bit of a symbol also loads `symbol_out`/`symbol_valid`. The result is visible after that edge, so latency is 1 clk from the last bit.
- In LOCKED with a steady phase, `symbol_valid` is high exactly 1 cycle in every 10.
- `aligned` rises on the edge that samples the last bit of the first comma.
- `comma_det` pulses on the same edge as the match.
- Reset asserted mid-symbol clears outputs asynchronously. After deassertion the block starts in HUNT with an empty shift register, and the first comma needs 10 fresh bits.

## Structure
- Shared package `serdes_rx_pkg`:
  - `K28_5_RDN` / `K28_5_RDP` 10-bit constants.
  - `align_state_t` enum {HUNT, LOCKED}.
  - `SYMBOL_W = 10`.
- Sub-module `comma_detector`: purely combinational 10-bit match against both disparities, reused later by the word aligner in the deserializer.

## Test plan
- **First lock:** reset, then stream 3 random bits followed by K28.5 RD- (0011111010) and D21.5 (1010101010) repeated.
  - `aligned` rises with the comma's last bit.
  - `symbol_out` = 0x0FA, then 0x2AA.
  - Valid every 10 cycles.
- **Slicer threshold:** feed 0.49 and 0.51 for the same comma stream. 0.49 slices as 0 and 0.51 as 1; check that `sr` gives the expected comma at the correct bit.
- **Single off-phase comma:** while locked, slip the stream by 1 bit once.
  - `comma_det` pulses; `realign_count` stays 0.
  - Boundary is unchanged until the third consecutive off-phase comma.
  - On the third: re-phase, `realign_count` = 1, and the next valid comes 10 cycles later.
- **Timeout:** `COMMA_TIMEOUT` = 4, lock, then send 4 non-comma symbols. `aligned` falls on the 4th symbol's boundary edge and `symbol_valid` stops.
- **Reset mid-operation:** assert `reset` at bit 5 of a locked symbol.
  - All outputs are 0 immediately.
  - After release, no valid strobe appears until a full comma has been received.
- **Saturation:** force 260 re-phase events with `MISALIGN_LIMIT` = 1. `realign_count` holds at 255.
